// File: rtl/w5300_bus_master.sv
// rtl/w5300_bus_master.sv - W5300 direct-mode parallel bus master; optional W5300_BUS_RDATA_IREG_EN registers read data in an input flop
module w5300_bus_master #(
  parameter int CLK_FREQ_MHZ = 100,
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 16,
  parameter int T_AS_NS      = 10,
  parameter int T_STB_NS     = 65,
  parameter int T_HOLD_NS    = 10,
  parameter int T_REC_NS     = 30
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_wr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_data_o,
  output logic              bus_data_oe,
  input  logic [DATA_W-1:0] bus_data_i,
  output logic              bus_cs_n,
  output logic              bus_rd_n,
  output logic              bus_we_n
);

  localparam int N_AS_RAW = (T_AS_NS * CLK_FREQ_MHZ + 999) / 1000;
  localparam int N_STB_RAW = (T_STB_NS * CLK_FREQ_MHZ + 999) / 1000;
  localparam int N_AS = (N_AS_RAW < 1) ? 1 : N_AS_RAW;
  localparam int N_STB = (N_STB_RAW < 1) ? 1 : N_STB_RAW;
  localparam int N_HOLD = (T_HOLD_NS * CLK_FREQ_MHZ + 999) / 1000;
  localparam int N_REC = (T_REC_NS * CLK_FREQ_MHZ + 999) / 1000;

  localparam logic [7:0] AS_M1 = 8'(N_AS - 1);
  localparam logic [7:0] STB_M1 = 8'(N_STB - 1);
  localparam logic [7:0] HOLD_M1 = 8'(N_HOLD - 1);
  localparam logic [7:0] REC_M1 = 8'(N_REC - 1);

`ifdef W5300_BUS_RDATA_IREG_EN
  localparam bit IREG = 1'b1;
`else
  localparam bit IREG = 1'b0;
`endif

  generate
    if (DATA_W != 8 && DATA_W != 16) begin : g_bad_data_w
      $error("w5300_bus_master: DATA_W must be 8 or 16");
    end
    if (N_AS > 255 || N_STB > 255 || N_HOLD > 255 || N_REC > 255) begin : g_bad_ticks
      $error("w5300_bus_master: a phase needs more than 255 clk ticks");
    end
  endgenerate

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER} state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              wr_q, wr_d;
  logic              rd_pend_q, rd_pend_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_wr_q, rsp_wr_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_data_o_q, bus_data_o_d;
  logic              bus_data_oe_q, bus_data_oe_d;
  logic              bus_cs_n_q, bus_cs_n_d;
  logic              bus_rd_n_q, bus_rd_n_d;
  logic              bus_we_n_q, bus_we_n_d;
  logic [DATA_W-1:0] rd_cap;

`ifdef W5300_BUS_RDATA_IREG_EN
  logic [DATA_W-1:0] din_q;

  // Input flop on the data pad, sampled every clock so it can sit in the IOB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) din_q <= '0;
    else        din_q <= bus_data_i;
  end
  assign rd_cap = din_q;
`else
  assign rd_cap = bus_data_i;
`endif

  // req_ready is raised for the final occupancy cycle so the next request is
  // accepted on the very edge that ends the current bus cycle.
  function automatic logic is_last(state_t st, logic [7:0] cnt, logic wr);
    case (st)
      IDLE:    is_last = 1'b1;
      STROBE:  is_last = (N_HOLD == 0) && (N_REC == 0) && (cnt == 8'd0) && !(IREG && !wr);
      HOLD:    is_last = (N_REC == 0) && (cnt == 8'd0);
      RECOVER: is_last = (cnt == 8'd0);
      default: is_last = 1'b0;
    endcase
  endfunction

  // Next-state and next-output computation for the bus cycle sequencer.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wr_d          = wr_q;
    rd_pend_d     = 1'b0;
    rsp_valid_d   = 1'b0;
    rsp_wr_d      = rsp_wr_q;
    rsp_rdata_d   = rsp_rdata_q;
    bus_addr_d    = bus_addr_q;
    bus_data_o_d  = bus_data_o_q;
    bus_data_oe_d = bus_data_oe_q;
    bus_cs_n_d    = bus_cs_n_q;
    bus_rd_n_d    = bus_rd_n_q;
    bus_we_n_d    = bus_we_n_q;

    case (state_q)
      SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d    = STROBE;
          cnt_d      = STB_M1;
          bus_rd_n_d = wr_q;
          bus_we_n_d = !wr_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      STROBE: begin
        if (cnt_q == 8'd0) begin
          bus_rd_n_d = 1'b1;
          bus_we_n_d = 1'b1;
          if (IREG && !wr_q) begin
            rd_pend_d = 1'b1;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_wr_d    = wr_q;
            if (!wr_q) rsp_rdata_d = rd_cap;
          end
          if (N_HOLD > 0) begin
            state_d = HOLD;
            cnt_d   = HOLD_M1;
          end else begin
            state_d       = (N_REC > 0 || (IREG && !wr_q)) ? RECOVER : IDLE;
            cnt_d         = (N_REC > 0) ? REC_M1 : 8'd0;
            bus_cs_n_d    = 1'b1;
            bus_data_oe_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d       = (N_REC > 0) ? RECOVER : IDLE;
          cnt_d         = REC_M1;
          bus_cs_n_d    = 1'b1;
          bus_data_oe_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      RECOVER: begin
        if (cnt_q == 8'd0) state_d = IDLE;
        else               cnt_d = cnt_q - 8'd1;
      end
      default: ;
    endcase

    // Delayed read completion from the input flop.
    if (rd_pend_q) begin
      rsp_valid_d = 1'b1;
      rsp_wr_d    = 1'b0;
      rsp_rdata_d = rd_cap;
    end

    // Accept overrides the bus outputs of the cycle that is just ending.
    if (req_ready_q && req_valid) begin
      state_d       = SETUP;
      cnt_d         = AS_M1;
      wr_d          = req_wr;
      bus_addr_d    = req_addr;
      bus_cs_n_d    = 1'b0;
      bus_rd_n_d    = 1'b1;
      bus_we_n_d    = 1'b1;
      bus_data_oe_d = req_wr;
      if (req_wr) bus_data_o_d = req_wdata;
    end

    req_ready_d = is_last(state_d, cnt_d, wr_d);
  end

  // State and registered outputs; reset aborts any cycle in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 8'd0;
      wr_q          <= 1'b0;
      rd_pend_q     <= 1'b0;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_wr_q      <= 1'b0;
      rsp_rdata_q   <= '0;
      bus_addr_q    <= '0;
      bus_data_o_q  <= '0;
      bus_data_oe_q <= 1'b0;
      bus_cs_n_q    <= 1'b1;
      bus_rd_n_q    <= 1'b1;
      bus_we_n_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_q          <= wr_d;
      rd_pend_q     <= rd_pend_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_wr_q      <= rsp_wr_d;
      rsp_rdata_q   <= rsp_rdata_d;
      bus_addr_q    <= bus_addr_d;
      bus_data_o_q  <= bus_data_o_d;
      bus_data_oe_q <= bus_data_oe_d;
      bus_cs_n_q    <= bus_cs_n_d;
      bus_rd_n_q    <= bus_rd_n_d;
      bus_we_n_q    <= bus_we_n_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_wr      = rsp_wr_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign bus_addr    = bus_addr_q;
  assign bus_data_o  = bus_data_o_q;
  assign bus_data_oe = bus_data_oe_q;
  assign bus_cs_n    = bus_cs_n_q;
  assign bus_rd_n    = bus_rd_n_q;
  assign bus_we_n    = bus_we_n_q;

endmodule

// File: tb/tb_w5300_bus_master.sv
// tb/tb_w5300_bus_master.sv - directed table-driven bench for w5300_bus_master at 100 MHz defaults
module tb_w5300_bus_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [9:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_wr;
  logic [15:0] rsp_rdata;
  logic [9:0]  bus_addr;
  logic [15:0] bus_data_o;
  logic        bus_data_oe;
  logic [15:0] bus_data_i;
  logic        bus_cs_n;
  logic        bus_rd_n;
  logic        bus_we_n;

  int n_chk = 0;
  int n_pass = 0;

`ifdef W5300_BUS_RDATA_IREG_EN
  localparam int RSP_E = 9;
`else
  localparam int RSP_E = 8;
`endif

  always #5 clk = ~clk;

  w5300_bus_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_wr(rsp_wr), .rsp_rdata(rsp_rdata),
    .bus_addr(bus_addr), .bus_data_o(bus_data_o), .bus_data_oe(bus_data_oe),
    .bus_data_i(bus_data_i), .bus_cs_n(bus_cs_n), .bus_rd_n(bus_rd_n), .bus_we_n(bus_we_n)
  );

  typedef struct {
    logic        wr;
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic [15:0] pad;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One request, sampled #1 after edges E0..E11.
  task automatic run_vec(input int idx, input vec_t v);
    logic [11:0] cs_m, rd_m, we_m, oe_m, rv_m, rdy_m;
    logic        got_wr;
    logic [15:0] got_rdata;
    int          bad_addr, bad_data, overlap;
    bad_addr = 0; bad_data = 0; overlap = 0;
    got_wr = 1'bx; got_rdata = 16'hxxxx;
    @(negedge clk);
    req_valid = 1'b1; req_wr = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    bus_data_i = ~v.pad;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wr = ~v.wr; req_addr = ~v.addr; req_wdata = ~v.wdata;
    for (int e = 0; e < 12; e++) begin
      cs_m[e] = bus_cs_n; rd_m[e] = bus_rd_n; we_m[e] = bus_we_n;
      oe_m[e] = bus_data_oe; rv_m[e] = rsp_valid; rdy_m[e] = req_ready;
      if (rsp_valid) begin got_wr = rsp_wr; got_rdata = rsp_rdata; end
      if (!bus_cs_n && bus_addr !== v.addr) bad_addr++;
      if (bus_data_oe && bus_data_o !== v.wdata) bad_data++;
      if (bus_data_oe && !bus_rd_n) overlap++;
      if (e == 5) bus_data_i = v.pad;
      if (e == 8) bus_data_i = 16'h0BAD;
      @(posedge clk); #1;
    end
    chk($sformatf("v%0d cs_n", idx), 32'(cs_m), 32'hE00);
    chk($sformatf("v%0d rd_n", idx), 32'(rd_m), v.wr ? 32'hFFF : 32'hF01);
    chk($sformatf("v%0d we_n", idx), 32'(we_m), v.wr ? 32'hF01 : 32'hFFF);
    chk($sformatf("v%0d oe", idx), 32'(oe_m), v.wr ? 32'h1FF : 32'h000);
    chk($sformatf("v%0d rsp_valid", idx), 32'(rv_m), 32'(1) << (v.wr ? 8 : RSP_E));
    chk($sformatf("v%0d req_ready", idx), 32'(rdy_m), 32'h800);
    chk($sformatf("v%0d rsp_wr", idx), 32'(got_wr), 32'(v.wr));
    chk($sformatf("v%0d rsp_rdata", idx), 32'(got_rdata), 32'(v.exp_rdata));
    chk($sformatf("v%0d addr/data/overlap errs", idx), 32'(bad_addr + bad_data + overlap), 32'd0);
  endtask

  initial begin
    logic [24:0] cs_b, rd_b, we_b, rv_b;
    int          ovl, rv_seen;
    logic [15:0] b2b_rdata;

    vecs[0] = '{1'b0, 10'h208, 16'h0000, 16'hA5C3, 16'hA5C3};
    vecs[1] = '{1'b1, 10'h001, 16'h1234, 16'hDEAD, 16'hA5C3};
    vecs[2] = '{1'b0, 10'h3FF, 16'h0000, 16'h0000, 16'h0000};
    vecs[3] = '{1'b1, 10'h3FF, 16'hFFFF, 16'h5555, 16'h0000};
    vecs[4] = '{1'b0, 10'h155, 16'h0000, 16'h5A5A, 16'h5A5A};
    vecs[5] = '{1'b1, 10'h2AA, 16'h00FF, 16'h1111, 16'h5A5A};

    // Reset with request activity.
    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; bus_data_i = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1; req_valid = ~req_valid; req_wr = 1'b1; req_addr = 10'h123;
    end
    @(negedge clk);
    chk("rst cs/rd/we", {29'd0, bus_cs_n, bus_rd_n, bus_we_n}, 32'h7);
    chk("rst oe/ready/rsp", {29'd0, bus_data_oe, req_ready, rsp_valid}, 32'h2);
    chk("rst addr/rdata", {bus_addr, rsp_rdata}, 32'h0);
    req_valid = 1'b0; rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Back-to-back: write then read with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 10'h0AA; req_wdata = 16'hBEEF; bus_data_i = 16'h1357;
    @(posedge clk); #1;
    req_wr = 1'b0; req_addr = 10'h155;
    ovl = 0; rv_seen = 0; b2b_rdata = 16'h0;
    for (int e = 0; e < 25; e++) begin
      cs_b[e] = bus_cs_n; rd_b[e] = bus_rd_n; we_b[e] = bus_we_n; rv_b[e] = rsp_valid;
      if (bus_data_oe && !bus_rd_n) ovl++;
      if (rsp_valid && !rsp_wr) b2b_rdata = rsp_rdata;
      if (e == 12) req_valid = 1'b0;
      @(posedge clk); #1;
    end
    chk("b2b cs_n", 32'(cs_b), 32'h1E00E00);
    chk("b2b we_n", 32'(we_b), 32'h1FFFF01);
    chk("b2b rd_n", 32'(rd_b), 32'h1F01FFF);
    chk("b2b rsp_valid", 32'(rv_b), (32'(1) << 8) | (32'(1) << (12 + RSP_E)));
    chk("b2b oe/rd overlap", 32'(ovl), 32'd0);
    chk("b2b rdata", 32'(b2b_rdata), 32'h1357);

    // Reset at E4 of a read.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 10'h208; bus_data_i = 16'hA5C3;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort in strobe", {31'd0, bus_rd_n}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("abort cs/rd/we", {29'd0, bus_cs_n, bus_rd_n, bus_we_n}, 32'h7);
    chk("abort oe/ready/rsp", {29'd0, bus_data_oe, req_ready, rsp_valid}, 32'h2);
    chk("abort addr", 32'(bus_addr), 32'h0);
    rv_seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (rsp_valid) rv_seen++;
      if (i == 3) rst_n = 1'b1;
    end
    chk("abort no rsp", 32'(rv_seen), 32'd0);
    run_vec(6, vecs[0]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/w5300_bus_master.md
Name: w5300_bus_master

Overview:
- Parametrised successor to the W5300 parallel-interface read/write engine.
- Executes one direct-mode bus cycle per accepted request. Setup, strobe, hold and recovery are each timed separately in clk ticks, derived from ns parameters.
- Sits between the socket/register controller (valid/ready requests, one-cycle responses) and the chip pins.
- The data bus is split into i/o/oe so the top-level pad wrapper owns the tristate.

Parameters:
- CLK_FREQ_MHZ, 100, clk frequency in MHz.
- ADDR_W, 10, bus address width.
- DATA_W, 16, bus data width; 8 or 16 only.
- T_AS_NS, 10, address/CS setup before strobe.
- T_STB_NS, 65, RD_n/WE_n low width.
- T_HOLD_NS, 10, address/CS/data hold after strobe.
- T_REC_NS, 30, CS_n high recovery between cycles.
- Ticks: N_x = ceil(T_x_NS*CLK_FREQ_MHZ/1000), computed at elaboration.
  - N_AS and N_STB are forced to a minimum of 1; N_HOLD and N_REC may be 0.
  - Any N above 255 is an elaboration error.
  - A DATA_W other than 8 or 16 is an elaboration error.
  - At 100 MHz: N_AS=1, N_STB=7, N_HOLD=1, N_REC=3.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  engine idle, request accepted on valid&ready
- req_wr  in  1  1=write, 0=read
- req_addr  in  ADDR_W  target address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_wr  out  1  direction of completed request
- rsp_rdata  out  DATA_W  read data; unchanged on write completion
- bus_addr  out  ADDR_W  chip address
- bus_data_o  out  DATA_W  data driven to chip
- bus_data_oe  out  1  1=FPGA drives data bus
- bus_data_i  in  DATA_W  data from pad
- bus_cs_n  out  1  chip select
- bus_rd_n  out  1  read strobe
- bus_we_n  out  1  write strobe

Behaviour:
- All outputs are registered.
- Reset values: req_ready=1, rsp_valid=0, rsp_wr=0, rsp_rdata=0, bus_addr=0, bus_data_o=0, bus_data_oe=0, bus_cs_n=1, bus_rd_n=1, bus_we_n=1.
- Assertion of rst_n mid-cycle forces these values immediately and aborts the cycle. No response is issued for an aborted cycle.
- FSM states: IDLE, SETUP, STROBE, HOLD, RECOVER. An 8-bit down-counter times each state.
- IDLE: req_ready=1. At accept edge E0:
  - Latch wr/addr/wdata.
  - bus_addr=addr, bus_cs_n=0.
  - For writes: bus_data_oe=1, bus_data_o=wdata.
  - req_ready=0; enter SETUP.
- SETUP: N_AS cycles, strobes high. Then enter STROBE and drive bus_rd_n=0 (read) or bus_we_n=0 (write).
- STROBE: N_STB cycles. At the exit edge:
  - Strobe returns high.
  - For reads: rsp_rdata<=bus_data_i.
  - rsp_valid=1 for exactly one cycle, rsp_wr=latched wr.
  - Enter HOLD; skip to RECOVER if N_HOLD=0; skip to IDLE if both N_HOLD and N_REC are 0.
- HOLD: cs_n low, addr and write data held, oe unchanged.
- RECOVER: bus_cs_n=1, bus_data_oe=0, bus_addr holds its last value (never Z).
- Return to IDLE with req_ready=1.
- Occupancy is N_AS+N_STB+N_HOLD+N_REC cycles from accept to req_ready high. The next request may be accepted at that edge.
- There is no rsp backpressure; the consumer must take the pulse.
- req_* are ignored while req_ready=0. Changes to req_* after acceptance do not affect the running cycle.
- bus_data_oe never rises while bus_rd_n=0.
- DATA_W=8: identical protocol with an 8-bit data path.

Optional Feature:
- Macro: W5300_BUS_RDATA_IREG_EN.
- Defined:
  - bus_data_i is registered every clk in an input flop (IOB).
  - Read capture uses the flop value one edge after STROBE exit, i.e. the pad value sampled at the STROBE exit edge.
  - rsp_valid/rsp_rdata for reads appear one cycle later than without the macro.
  - Write response timing is unchanged. Occupancy is unchanged; if N_HOLD+N_REC=0, the engine occupies one extra cycle for reads.
- Undefined: the pad is sampled directly at the STROBE exit edge.

Test Plan:
- Reset: hold rst_n=0, toggle req_valid -> cs_n/rd_n/we_n=1, oe=0, req_ready=1, rsp_valid=0.
- Read, 100 MHz defaults: req addr=0x208, bus_data_i=0xA5C3 -> cs_n low E0..E9, rd_n low E1..E8, rsp_valid at E8 with 0xA5C3, req_ready high at E12.
- Write: addr=0x001, wdata=0x1234 -> oe=1 and data_o=0x1234 from E0 to E9, we_n low E1..E8, rd_n stays 1, rsp_valid with rsp_wr=1 at E8.
- Back-to-back: req_valid held high with write then read -> second accept exactly at E12, cs_n high for E9..E12, no oe/rd_n overlap.
- Reset at E4 of a read -> outputs return to reset immediately, no rsp_valid; a new request is accepted cleanly after release.
- With W5300_BUS_RDATA_IREG_EN, read 0x5A5A -> rsp_valid at E9 with 0x5A5A.
